// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master round-robin data-bus arbiter with registered grant, one transaction in flight.
// Define ARB_TIMEOUT_EN to add a slave-wait counter that forces an error completion after TIMEOUT_CYC cycles.
module dbus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                m0_valid,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_valid,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_valid,
    output logic                s_write,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          grant_o,
    output logic                err_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;
    state_t state_q, state_d;
    logic last_q, last_d;
    logic sel1, act, own_valid, other_valid, done, tmo;
    logic [DATA_W-1:0] rd;

    assign grant_o     = state_q;
    assign sel1        = state_q == G1;
    assign act         = state_q != IDLE && !sys_rst;
    assign own_valid   = sel1 ? m1_valid : m0_valid;
    assign other_valid = sel1 ? m0_valid : m1_valid;
    assign err_o       = tmo;

    always_comb begin
        s_valid  = act && own_valid && !tmo;
        s_write  = sel1 ? m1_write : m0_write;
        s_addr   = sel1 ? m1_addr : m0_addr;
        s_wdata  = sel1 ? m1_wdata : m0_wdata;
        s_wstrb  = sel1 ? m1_wstrb : m0_wstrb;
        done     = (s_valid && s_ready) || tmo;
        m0_ready = done && !sel1;
        m1_ready = done && sel1;
        rd       = tmo ? DATA_W'(32'hDEAD_BEEF) : s_rdata;
        m0_rdata = (act && !sel1) ? rd : '0;
        m1_rdata = (act && sel1) ? rd : '0;
    end

    // last_q names the most recent completer; on a tie the other master wins
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            state_d = (m0_valid && (!m1_valid || last_q)) ? G0 : m1_valid ? G1 : IDLE;
        end else if (done) begin
            last_d  = sel1;
            state_d = other_valid ? (sel1 ? G0 : G1) : own_valid ? state_q : IDLE;
        end else if (!own_valid) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign tmo = act && own_valid && cnt_q == CW'(TIMEOUT_CYC);

    always_comb begin
        cnt_d = (s_valid && !s_ready) ? cnt_q + CW'(1) : '0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed scoreboard bench for dbus_arbiter with a zero/stalled-wait slave model.
module tb_dbus_arbiter;
    localparam logic [31:0] K = 32'h1234_4678;

    typedef struct {logic w; logic [31:0] a; logic [31:0] d; logic [3:0] s;} req_t;
    typedef struct {logic [31:0] addr; logic [31:0] rd;} exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic m0_valid = 1'b0, m0_write = 1'b0, m1_valid = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0] m0_wstrb = '0, m1_wstrb = '0;
    logic m0_ready, m1_ready, s_valid, s_write, err_o;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
    logic [3:0] s_wstrb;
    logic [1:0] grant_o;
    logic sr = 1'b1;

    req_t req0[$], req1[$];
    exp_t q0[$], q1[$];
    logic [1:0] gseq[$];
    int ncmp = 0, nerr = 0, c0 = 0, c1 = 0, ecnt = 0;
    logic r0 = 1'b0, r1 = 1'b0;

    always #5 sys_clk = ~sys_clk;

    // slave read data is a fixed function of the address
    assign s_rdata = s_addr ^ K;

    dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_valid(m0_valid), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(sr), .s_rdata(s_rdata),
        .grant_o(grant_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        ncmp++;
        assert (obs === want) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic push0(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req0.push_back('{w: w, a: a, d: d, s: s});
    endtask

    task automatic push1(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req1.push_back('{w: w, a: a, d: d, s: s});
    endtask

    // negedge: score completions; posedge+1: masters present next request or drop valid
    task automatic step();
        exp_t e;
        req_t rq;
        @(negedge sys_clk);
        chk("ready_exclusive", 32'(m0_ready & m1_ready), 0);
        if (err_o) ecnt++;
        if (m0_ready) begin
            if (q0.size() == 0) chk("m0_spurious_ready", 32'(m0_ready), 0);
            else begin
                e = q0.pop_front();
                chk("m0_rdata", m0_rdata, e.rd);
                chk("m0_addr", s_addr, e.addr);
                chk("m1_rdata_zero", m1_rdata, 0);
            end
            gseq.push_back(grant_o);
            c0++;
        end
        if (m1_ready) begin
            if (q1.size() == 0) chk("m1_spurious_ready", 32'(m1_ready), 0);
            else begin
                e = q1.pop_front();
                chk("m1_rdata", m1_rdata, e.rd);
                chk("m1_addr", s_addr, e.addr);
                chk("m0_rdata_zero", m0_rdata, 0);
            end
            gseq.push_back(grant_o);
            c1++;
        end
        r0 = m0_ready;
        r1 = m1_ready;
        @(posedge sys_clk);
        #1;
        if ((r0 || !m0_valid) && req0.size() > 0) begin
            rq = req0.pop_front();
            m0_write = rq.w; m0_addr = rq.a; m0_wdata = rq.d; m0_wstrb = rq.s; m0_valid = 1'b1;
            q0.push_back('{addr: rq.a, rd: rq.a ^ K});
        end else if (r0) m0_valid = 1'b0;
        if ((r1 || !m1_valid) && req1.size() > 0) begin
            rq = req1.pop_front();
            m1_write = rq.w; m1_addr = rq.a; m1_wdata = rq.d; m1_wstrb = rq.s; m1_valid = 1'b1;
            q1.push_back('{addr: rq.a, rd: rq.a ^ K});
        end else if (r1) m1_valid = 1'b0;
    endtask

    initial begin
        int e0;
        step();
        step();
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_s_valid", 32'(s_valid), 0);
        chk("rst_m0_ready", 32'(m0_ready), 0);
        chk("rst_m1_ready", 32'(m1_ready), 0);
        chk("rst_err", 32'(err_o), 0);
        sys_rst = 1'b0;

        // single read, zero-wait slave
        push0(1'b0, 32'h1000, 32'h0, 4'h0);
        step();
        chk("t1_no_passthru_grant", 32'(grant_o), 0);
        chk("t1_no_passthru_svalid", 32'(s_valid), 0);
        step();
        chk("t1_grant", 32'(grant_o), 1);
        chk("t1_m0_ready", 32'(m0_ready), 1);
        chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("t1_m1_ready", 32'(m1_ready), 0);
        chk("t1_s_addr", s_addr, 32'h1000);
        step();
        step();
        chk("t1_idle", 32'(grant_o), 0);

        // both masters, four writes each, alternate with no gaps
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push0(1'b1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 4'hF);
            push1(1'b1, 32'h200 + 32'(4 * i), 32'hB000 + 32'(i), 4'hF);
        end
        gseq.delete();
        c0 = 0;
        c1 = 0;
        step();
        for (int i = 0; i < 9; i++) step();
        chk("t2_m0_count", 32'(c0), 4);
        chk("t2_m1_count", 32'(c1), 4);
        for (int i = 0; i < 8; i++) chk("t2_grant_order", 32'(gseq[i]), (i % 2 == 0) ? 1 : 2);
        step();
        step();
        chk("t2_idle", 32'(grant_o), 0);

        // m1 write held by five slave wait states while m0 requests
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        sr = 1'b0;
        push1(1'b1, 32'h2000, 32'hCAFE_F00D, 4'b0100);
        step();
        step();
        push0(1'b0, 32'h3000, 32'h0, 4'h0);
        for (int i = 1; i <= 5; i++) begin
            chk("t3_grant", 32'(grant_o), 2);
            chk("t3_s_addr", s_addr, 32'h2000);
            chk("t3_s_wdata", s_wdata, 32'hCAFE_F00D);
            chk("t3_s_wstrb", 32'(s_wstrb), 32'b0100);
            chk("t3_s_write", 32'(s_write), 1);
            chk("t3_m1_wait", 32'(m1_ready), 0);
            chk("t3_m0_wait", 32'(m0_ready), 0);
            step();
        end
        sr = 1'b1;
        #1;
        chk("t3_m1_ready", 32'(m1_ready), 1);
        step();
        chk("t3_m0_granted", 32'(grant_o), 1);
        chk("t3_m0_ready", 32'(m0_ready), 1);
        step();
        step();
        chk("t3_idle", 32'(grant_o), 0);

        // m0 abandons with last=0: m1 wins the following tie
        sr = 1'b0;
        push0(1'b0, 32'h4000, 32'h0, 4'h0);
        step();
        step();
        chk("t4a_grant", 32'(grant_o), 1);
        step();
        m0_valid = 1'b0;
        void'(q0.pop_front());
        #1;
        chk("t4a_abandon_svalid", 32'(s_valid), 0);
        chk("t4a_abandon_ready", 32'(m0_ready), 0);
        step();
        chk("t4a_idle", 32'(grant_o), 0);
        push0(1'b0, 32'h5000, 32'h0, 4'h0);
        push1(1'b0, 32'h6000, 32'h0, 4'h0);
        sr = 1'b1;
        step();
        step();
        chk("t4a_tie_m1", 32'(grant_o), 2);
        chk("t4a_m1_ready", 32'(m1_ready), 1);
        step();
        chk("t4a_then_m0", 32'(grant_o), 1);
        step();
        step();

        // m1 abandons with last=0: last stays 0, so m1 still wins the tie
        sr = 1'b0;
        push1(1'b0, 32'h6100, 32'h0, 4'h0);
        step();
        step();
        chk("t4b_grant", 32'(grant_o), 2);
        m1_valid = 1'b0;
        void'(q1.pop_front());
        step();
        chk("t4b_idle", 32'(grant_o), 0);
        push0(1'b0, 32'h5100, 32'h0, 4'h0);
        push1(1'b0, 32'h6200, 32'h0, 4'h0);
        sr = 1'b1;
        step();
        step();
        chk("t4b_tie_m1", 32'(grant_o), 2);
        step();
        step();
        step();

        // reset during a stalled m1 transaction
        sr = 1'b0;
        push1(1'b1, 32'h7000, 32'h55, 4'hF);
        step();
        step();
        chk("t5_grant", 32'(grant_o), 2);
        step();
        sys_rst = 1'b1;
        #1;
        chk("t5_rst_svalid_now", 32'(s_valid), 0);
        step();
        chk("t5_grant_idle", 32'(grant_o), 0);
        chk("t5_s_valid", 32'(s_valid), 0);
        chk("t5_m0_ready", 32'(m0_ready), 0);
        chk("t5_m1_ready", 32'(m1_ready), 0);
        m1_valid = 1'b0;
        void'(q1.pop_front());
        sys_rst = 1'b0;
        push0(1'b0, 32'h7100, 32'h0, 4'h0);
        push1(1'b0, 32'h7200, 32'h0, 4'h0);
        sr = 1'b1;
        step();
        step();
        chk("t5_m0_first", 32'(grant_o), 1);
        step();
        step();
        step();

        // unresponsive slave
        sr = 1'b0;
        push0(1'b0, 32'h8000, 32'h0, 4'h0);
        step();
`ifdef ARB_TIMEOUT_EN
        void'(q0.pop_back());
        q0.push_back('{addr: 32'h8000, rd: 32'hDEAD_BEEF});
        step();
        for (int i = 0; i < 8; i++) begin
            chk("t6_wait_ready", 32'(m0_ready), 0);
            chk("t6_wait_err", 32'(err_o), 0);
            step();
        end
        chk("t6_tmo_ready", 32'(m0_ready), 1);
        chk("t6_tmo_err", 32'(err_o), 1);
        chk("t6_tmo_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t6_tmo_svalid", 32'(s_valid), 0);
        step();
        step();
        chk("t6_err_count", 32'(ecnt), 1);
`else
        e0 = c0;
        for (int i = 0; i < 1000; i++) step();
        chk("t6_no_completion", 32'(c0), 32'(e0));
        chk("t6_grant_held", 32'(grant_o), 1);
        chk("t6_err_count", 32'(ecnt), 0);
        sys_rst = 1'b1;
        m0_valid = 1'b0;
        void'(q0.pop_front());
        step();
        sys_rst = 1'b0;
`endif
        chk("end_q0_empty", 32'(q0.size()), 0);
        chk("end_q1_empty", 32'(q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end
endmodule
